// File: rtl/output_mems.sv
// Result buffer: captures the M x N result matrix written by the compute unit
// into a local single-port RAM, then streams it out row-major over AXI-Stream.
module output_mems #(
  parameter int unsigned OUTW = 24,
  parameter int unsigned M    = 7,
  parameter int unsigned N    = 9,
  // Held at least 1 bit wide so a 1x1 matrix still gets a legal address bus
  localparam int unsigned C_ADDR_BITS = (M * N > 1) ? $clog2(M * N) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [C_ADDR_BITS-1:0] C_wr_addr,
  input  logic [OUTW-1:0]        C_wr_data,
  input  logic                   C_wr_en,
  input  logic                   results_ready,
  output logic                   output_busy,
  output logic                   output_done,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
  output logic                   AXIS_TLAST,
  input  logic                   AXIS_TREADY
);

  localparam int unsigned Depth = 1 << C_ADDR_BITS;
  localparam logic [C_ADDR_BITS-1:0] LastAddr = C_ADDR_BITS'(M * N - 1);

  typedef enum logic [1:0] {StIdle, StPrime, StFill, StStream} state_e;

  state_e                 state_q, state_d;
  logic [C_ADDR_BITS-1:0] rd_cnt_q, rd_cnt_d;  // next RAM address to fetch
  logic [C_ADDR_BITS-1:0] el_cnt_q, el_cnt_d;  // index of element in the output register
  logic [OUTW-1:0]        tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   done_q, done_d;

  logic [OUTW-1:0]        mem [Depth];
  logic [OUTW-1:0]        rd_data_q;
  logic                   ram_we, ram_re;
  logic [C_ADDR_BITS-1:0] ram_addr;
  logic                   xfer;
  logic [C_ADDR_BITS-1:0] rd_cnt_inc;
  logic [C_ADDR_BITS-1:0] el_cnt_nxt;

  assign xfer       = tvalid_q & AXIS_TREADY;
  // Read pointer saturates on the last element; re-reading it is harmless
  assign rd_cnt_inc = (rd_cnt_q == LastAddr) ? rd_cnt_q : rd_cnt_q + 1'b1;
  assign el_cnt_nxt = el_cnt_q + 1'b1;

  // Next-state logic: compute owns the RAM in idle, the streamer otherwise.
  // rd_data_q always holds the element after the one in the output register,
  // so each handshake reloads the output register with no bubble.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    el_cnt_d = el_cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    done_d   = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = C_wr_addr;
    unique case (state_q)
      StIdle: begin
        rd_cnt_d = '0;
        el_cnt_d = '0;
        ram_we   = C_wr_en && (C_wr_addr <= LastAddr);
        if (results_ready) state_d = StPrime;
      end
      StPrime: begin
        ram_re   = 1'b1;
        ram_addr = rd_cnt_q;
        rd_cnt_d = rd_cnt_inc;
        state_d  = StFill;
      end
      StFill: begin
        ram_re   = 1'b1;
        ram_addr = rd_cnt_q;
        rd_cnt_d = rd_cnt_inc;
        tdata_d  = rd_data_q;
        tvalid_d = 1'b1;
        tlast_d  = (el_cnt_q == LastAddr);
        state_d  = StStream;
      end
      StStream: begin
        if (xfer) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
            rd_cnt_d = '0;
            el_cnt_d = '0;
            state_d  = StIdle;
          end else begin
            el_cnt_d = el_cnt_nxt;
            tdata_d  = rd_data_q;
            tlast_d  = (el_cnt_nxt == LastAddr);
            ram_re   = 1'b1;
            ram_addr = rd_cnt_q;
            rd_cnt_d = rd_cnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rd_cnt_q <= '0;
      el_cnt_q <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      el_cnt_q <= el_cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
    end
  end

  // Single-port result RAM with registered read; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= C_wr_data;
    if (ram_re) rd_data_q <= mem[ram_addr];
  end

  assign output_busy = (state_q != StIdle);
  assign output_done = done_q;
  assign AXIS_TDATA  = tdata_q;
  assign AXIS_TVALID = tvalid_q;
  assign AXIS_TLAST  = tlast_q;

endmodule
